// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle for the data-memory access controller: core request/response
// handshake on one side, byte-masked SRAM port on the other.
interface dmem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_BYTE  = DATA_WIDTH / 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  ram_cs;
  logic [DATA_BYTE-1:0]  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_cs, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_cs, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store access controller: turns one byte-addressed request at a time
// into a masked SRAM access and returns an extended load word or an error.
module dmem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_BYTE  = DATA_WIDTH / 8
) (
  input logic               clk,
  input logic               rst,
  dmem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  req_ready_s;
  logic                  handshake_s;
  logic                  req_err_s;
  logic                  we_r;
  logic [1:0]            size_r;
  logic                  unsigned_r;
  logic [1:0]            off_r;
  logic                  ram_cs_r;
  logic [DATA_BYTE-1:0]  ram_we_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_wdata_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;

  function automatic logic addr_error(input logic [1:0] size, input logic [31:0] addr);
    logic bad_s;
    case (size)
      2'b00:   bad_s = 1'b0;
      2'b01:   bad_s = addr[0];
      2'b10:   bad_s = (addr[1:0] != 2'b00);
      default: bad_s = 1'b1;
    endcase
    // Anything above the SRAM's byte range is rejected outright.
    bad_s = bad_s | ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
    return bad_s;
  endfunction

  function automatic logic [DATA_BYTE-1:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    logic [DATA_BYTE-1:0] mask_s;
    case (size)
      2'b00:   mask_s = {{(DATA_BYTE-1){1'b0}}, 1'b1} << off;
      2'b01:   mask_s = {{(DATA_BYTE-2){1'b0}}, 2'b11} << off;
      default: mask_s = {DATA_BYTE{1'b1}};
    endcase
    return mask_s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic [1:0] size, input logic [DATA_WIDTH-1:0] wdata);
    logic [DATA_WIDTH-1:0] lanes_s;
    case (size)
      2'b00:   lanes_s = {DATA_BYTE{wdata[7:0]}};
      2'b01:   lanes_s = {(DATA_BYTE/2){wdata[15:0]}};
      default: lanes_s = wdata;
    endcase
    return lanes_s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] rdata,
                                                        input logic [1:0] size,
                                                        input logic [1:0] off,
                                                        input logic uns);
    logic [DATA_WIDTH-1:0] byte_sh_s;
    logic [DATA_WIDTH-1:0] half_sh_s;
    logic [DATA_WIDTH-1:0] ext_s;
    byte_sh_s = rdata >> {off, 3'b000};
    half_sh_s = rdata >> {off[1], 4'b0000};
    case (size)
      2'b00:   ext_s = {{(DATA_WIDTH-8){~uns & byte_sh_s[7]}}, byte_sh_s[7:0]};
      2'b01:   ext_s = {{(DATA_WIDTH-16){~uns & half_sh_s[15]}}, half_sh_s[15:0]};
      default: ext_s = rdata;
    endcase
    return ext_s;
  endfunction

  assign req_ready_s = (state_r == IDLE) && !rst;
  assign handshake_s = bus.req_valid && req_ready_s;
  assign req_err_s   = addr_error(bus.req_size, bus.req_addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          state_nxt_s = req_err_s ? RESP : ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS:  state_nxt_s = we_r ? RESP : RD_WAIT;
      RD_WAIT: state_nxt_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request capture, SRAM controls and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r        <= 1'b0;
      size_r      <= 2'b00;
      unsigned_r  <= 1'b0;
      off_r       <= 2'b00;
      ram_cs_r    <= 1'b0;
      ram_we_r    <= {DATA_BYTE{1'b0}};
      ram_addr_r  <= {ADDR_WIDTH{1'b0}};
      ram_wdata_r <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (handshake_s) begin
            we_r       <= bus.req_we;
            size_r     <= bus.req_size;
            unsigned_r <= bus.req_unsigned;
            off_r      <= bus.req_addr[1:0];
            if (req_err_s) begin
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            end else begin
              ram_cs_r    <= 1'b1;
              ram_we_r    <= bus.req_we ? store_mask(bus.req_size, bus.req_addr[1:0])
                                        : {DATA_BYTE{1'b0}};
              ram_addr_r  <= bus.req_addr[ADDR_WIDTH+1:2];
              ram_wdata_r <= lane_data(bus.req_size, bus.req_wdata);
            end
          end
        end
        ACCESS: begin
          ram_cs_r <= 1'b0;
          ram_we_r <= {DATA_BYTE{1'b0}};
          if (we_r) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
          end
        end
        RD_WAIT: begin
          // SRAM read data is only valid in this one cycle.
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= load_extend(bus.ram_rdata, size_r, off_r, unsigned_r);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          ram_cs_r <= 1'b0;
          ram_we_r <= {DATA_BYTE{1'b0}};
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.ram_cs    = ram_cs_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: SRAM model plus a byte-array
// reference memory, directed scenarios and randomized load/store traffic.
module tb_dmem_access_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DB = 4;
  localparam int NBYTES = 4 << AW;

  logic clk = 1'b0;
  logic rst;
  logic fill;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTE(DB)) bus ();

  dmem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTE(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // SRAM model: read data valid only the cycle after a read select.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  logic          rd_v;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      rd_v <= 1'b0;
    end else if (bus.ram_cs && bus.ram_we == 4'b0000) begin
      rd_q <= mem[bus.ram_addr];
      rd_v <= 1'b1;
    end else begin
      rd_v <= 1'b0;
      if (bus.ram_cs) begin
        for (int i = 0; i < DB; i++)
          if (bus.ram_we[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
      end
    end
  end
  assign bus.ram_rdata = rd_v ? rd_q : 32'h0;

  // Reference model: flat little-endian byte memory.
  logic [7:0] ref_mem [0:NBYTES-1];

  function automatic bit exp_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    if ((addr % n) != 0) return 1'b1;
    if (addr >= NBYTES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input bit uns, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[addr + k]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] m;
    logic [31:0] base;
    int n;
    n = 1 << size;
    base = addr & ~32'd3;
    for (int i = 0; i < 4; i++) m[i] = (base + i >= addr) && (base + i < addr + n);
    return m;
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] l;
    int n;
    n = 1 << size;
    for (int i = 0; i < 4; i++) l[8*i +: 8] = wdata[8*(i % n) +: 8];
    return l;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 0; k < (1 << size); k++) ref_mem[addr + k] = wdata[8*k +: 8];
  endtask

  // Observations of the last transaction.
  int          o_lat;
  int          o_cs_cnt;
  logic        o_cs1;
  logic [3:0]  o_we1;
  logic [9:0]  o_addr1;
  logic [31:0] o_wdata1;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_stable;
  logic        o_ready_after;
  logic        o_valid_after;

  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int k;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom);
    bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    o_cs1 = bus.ram_cs;
    o_we1 = bus.ram_we;
    o_addr1 = bus.ram_addr;
    o_wdata1 = bus.ram_wdata;
    o_cs_cnt = 0;
    o_lat = -1;
    for (k = 1; k <= 20; k++) begin
      if (bus.ram_cs) o_cs_cnt++;
      if (bus.rsp_valid) begin
        o_lat = k;
        break;
      end
      @(negedge clk);
    end
    o_rdata = bus.rsp_rdata;
    o_err = bus.rsp_err;
    o_stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err ||
          bus.req_ready !== 1'b0 || bus.ram_cs !== 1'b0) o_stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    o_ready_after = bus.req_ready;
    o_valid_after = bus.rsp_valid;
  endtask

  task automatic test_reset();
    logic [95:0] outs;
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h10;
    bus.req_size = 2'b10;
    bus.req_we = 1'b1;
    repeat (2) @(negedge clk);
    outs = {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ram_cs,
            bus.ram_we, bus.ram_addr, bus.ram_wdata};
    checks++;
    if (outs !== 96'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] iw;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    ref_store(2'b10, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if ({o_cs1, o_we1, o_addr1, o_lat} !== {1'b1, 4'b1111, 10'd4, 32'd2}) begin
      failures++;
      $display("FAIL store_word cs=%b we=%b addr=%0d lat=%0d exp cs=1 we=1111 addr=4 lat=2",
               o_cs1, o_we1, o_addr1, o_lat);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    checks++;
    if ({o_rdata, o_err, o_lat, o_we1} !== {32'hDEAD_BEEF, 1'b0, 32'd3, 4'b0000}) begin
      failures++;
      $display("FAIL load_word rdata=%h err=%b lat=%0d we=%b exp DEADBEEF 0 3 0000",
               o_rdata, o_err, o_lat, o_we1);
    end
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0);
    ref_store(2'b00, 32'h13, 32'h80);
    checks++;
    if ({o_we1, o_wdata1} !== {4'b1000, 32'h8080_8080}) begin
      failures++;
      $display("FAIL store_byte we=%b wdata=%h exp 1000 80808080", o_we1, o_wdata1);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    checks++;
    if (o_rdata !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL load_byte_signed got=%h exp=FFFFFF80", o_rdata);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    checks++;
    if (o_rdata !== 32'h0000_0080) begin
      failures++;
      $display("FAIL load_byte_unsigned got=%h exp=00000080", o_rdata);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 0);
    ref_store(2'b01, 32'h22, 32'h8001);
    checks++;
    if ({o_we1, o_wdata1} !== {4'b1100, 32'h8001_8001}) begin
      failures++;
      $display("FAIL store_half we=%b wdata=%h exp 1100 80018001", o_we1, o_wdata1);
    end
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0);
    checks++;
    if (o_rdata !== 32'hFFFF_8001) begin
      failures++;
      $display("FAIL load_half_signed got=%h exp=FFFF8001", o_rdata);
    end
    iw = init_word(8);
    issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0);
    checks++;
    if (o_rdata !== {24'h0, iw[7:0]}) begin
      failures++;
      $display("FAIL load_byte_untouched got=%h exp=%h", o_rdata, {24'h0, iw[7:0]});
    end
  endtask

  task automatic test_errors();
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] addrs [4] = '{32'h2, 32'h1, 32'h0, 32'h1000};
    for (int i = 0; i < 4; i++) begin
      issue(1'(i & 1), sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, 0);
      checks++;
      if ({o_err, o_rdata, o_lat, o_cs_cnt, o_cs1} !== {1'b1, 32'h0, 32'd1, 32'd0, 1'b0}) begin
        failures++;
        $display("FAIL error_rsp case=%0d err=%b rdata=%h lat=%0d cs_cnt=%0d exp err=1 rdata=0 lat=1 cs_cnt=0",
                 i, o_err, o_rdata, o_lat, o_cs_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    checks++;
    if (o_stable !== 1'b1 || o_rdata !== exp_load(2'b10, 1'b0, 32'h10)) begin
      failures++;
      $display("FAIL backpressure stable=%b rdata=%h exp stable=1 rdata=%h",
               o_stable, o_rdata, exp_load(2'b10, 1'b0, 32'h10));
    end
    checks++;
    if ({o_ready_after, o_valid_after} !== 2'b10) begin
      failures++;
      $display("FAIL backpressure_release ready=%b valid=%b exp ready=1 valid=0",
               o_ready_after, o_valid_after);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [95:0] outs;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.ram_cs, bus.rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL midreset_access cs=%b rsp_valid=%b exp cs=1 rsp_valid=0", bus.ram_cs, bus.rsp_valid);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      outs = {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ram_cs,
              bus.ram_we, bus.ram_addr, bus.ram_wdata};
      checks++;
      if (outs !== 96'h0) begin
        failures++;
        $display("FAIL midreset_outputs cycle=%0d got=%h exp=0", c, outs);
      end
    end
    rst = 1'b0;
    ref_store(2'b10, 32'h40, 32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
    checks++;
    if ({o_rdata, o_err} !== {32'h1234_5678, 1'b0}) begin
      failures++;
      $display("FAIL midreset_load got=%h err=%b exp=12345678 err=0", o_rdata, o_err);
    end
  endtask

  task automatic test_random();
    bit          we, uns, e;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp_rd;
    int          r, mode, exp_lat;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      uns = 1'($urandom);
      r = $urandom_range(0, 7);
      sz = (r == 7) ? 2'b11 : 2'(r % 3);
      mode = $urandom_range(0, 9);
      a = (mode < 5) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, NBYTES - 1));
      if (mode == 0) a = $urandom;
      if (mode > 2 && sz != 2'b11) a = a & ~((32'h1 << sz) - 32'h1);
      wd = $urandom;
      e = exp_err(sz, a);
      exp_rd = (e || we) ? 32'h0 : exp_load(sz, uns, a);
      exp_lat = e ? 1 : (we ? 2 : 3);
      issue(we, sz, uns, a, wd, $urandom_range(0, 2));
      checks++;
      if ({o_err, o_rdata} !== {e, exp_rd}) begin
        failures++;
        $display("FAIL rand_rsp i=%0d we=%b sz=%0d a=%h err=%b rdata=%h exp err=%b rdata=%h",
                 i, we, sz, a, o_err, o_rdata, e, exp_rd);
      end
      checks++;
      if (o_lat != exp_lat || o_cs_cnt != (e ? 0 : 1)) begin
        failures++;
        $display("FAIL rand_timing i=%0d lat=%0d cs_cnt=%0d exp lat=%0d cs_cnt=%0d",
                 i, o_lat, o_cs_cnt, exp_lat, e ? 0 : 1);
      end
      checks++;
      if (o_stable !== 1'b1 || o_ready_after !== 1'b1 || o_valid_after !== 1'b0) begin
        failures++;
        $display("FAIL rand_handshake i=%0d stable=%b ready_after=%b valid_after=%b exp 1 1 0",
                 i, o_stable, o_ready_after, o_valid_after);
      end
      if (!e) begin
        checks++;
        if (o_addr1 !== a[11:2] ||
            o_we1 !== (we ? exp_mask(sz, a) : 4'b0000) ||
            (we && o_wdata1 !== exp_lanes(sz, wd))) begin
          failures++;
          $display("FAIL rand_ram i=%0d addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                   i, o_addr1, o_we1, o_wdata1, a[11:2], we ? exp_mask(sz, a) : 4'b0000,
                   exp_lanes(sz, wd));
        end
        if (we) ref_store(sz, a, wd);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = init_word(i) >> (8 * j);
    fill = 1'b1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    fill = 1'b0;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
